// File: rtl/uart_rx_if.sv
// uart_rx_if: tick/serial inputs and byte/status outputs of the UART receiver.
// UART_RX_PARITY_EN adds the ParityError signal.
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic                 Tick;
  logic                 RxD;
  logic [DATA_BITS-1:0] RxData;
  logic                 RxDone;
  logic                 FrameError;
  logic                 Busy;
`ifdef UART_RX_PARITY_EN
  logic                 ParityError;
  modport master (output Tick, RxD, input RxData, RxDone, FrameError, Busy, ParityError);
  modport slave  (input Tick, RxD, output RxData, RxDone, FrameError, Busy, ParityError);
`else
  modport master (output Tick, RxD, input RxData, RxDone, FrameError, Busy);
  modport slave  (input Tick, RxD, output RxData, RxDone, FrameError, Busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver with frame-error flag.
// UART_RX_PARITY_EN switches to 8E1 and adds ParityError.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t               r_state, w_next;
  logic [1:0]           r_sync;
  logic                 r_prev;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_done, r_ferr;
  logic                 w_rxs, w_fall, w_half, w_full, w_last;
`ifdef UART_RX_PARITY_EN
  logic                 r_par, r_perr;
`endif
  assign w_rxs  = r_sync[1];
  assign w_fall = r_prev & ~w_rxs;
  assign w_half = bus.Tick && r_tick == HALF;
  assign w_full = bus.Tick && r_tick == FULL;
  assign w_last = w_full && r_bit == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) {r_sync, r_prev} <= 3'b111;
    else begin
      r_sync <= {r_sync[0], bus.RxD};
      r_prev <= w_rxs;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_fall ? S_START : S_IDLE;
      S_START:  w_next = w_half ? (w_rxs ? S_IDLE : S_DATA) : S_START;
`ifdef UART_RX_PARITY_EN
      S_DATA:   w_next = w_last ? S_PARITY : S_DATA;
      S_PARITY: w_next = w_full ? S_STOP : S_PARITY;
`else
      S_DATA:   w_next = w_last ? S_STOP : S_DATA;
`endif
      S_STOP:   w_next = w_full ? S_IDLE : S_STOP;
      default:  w_next = S_IDLE;
    endcase
  end
  // the tick counter is a power-of-two width, so it wraps to 0 on its own every bit period
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_START: begin
          r_tick <= w_half ? '0 : r_tick + TW'(bus.Tick);
          r_bit  <= '0;
        end
        S_DATA: begin
          r_tick <= r_tick + TW'(bus.Tick);
          if (w_full) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_bit   <= r_bit + BW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          r_tick <= r_tick + TW'(bus.Tick);
          if (w_full) r_par <= w_rxs;
        end
`endif
        S_STOP: begin
          r_tick <= r_tick + TW'(bus.Tick);
          if (w_full) begin
            r_data <= r_shift;
            r_ferr <= ~w_rxs;
            r_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_perr <= ^{r_shift, r_par};
`endif
          end
        end
        default: r_tick <= '0;
      endcase
    end
  always_comb begin
    bus.RxData     = r_data;
    bus.RxDone     = r_done;
    bus.FrameError = r_ferr;
    bus.Busy       = r_state != S_IDLE;
`ifdef UART_RX_PARITY_EN
    bus.ParityError = r_perr;
`endif
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 16x oversampling; a scoreboard queue holds the
// expected byte/flags of each frame and is checked on every RxDone.
module tb_uart_rx;
  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0, n_err = 0, done_cnt = 0, tcnt = 0;
  logic prev_done = 1'b0;
  exp_t q[$];
  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    tcnt = (tcnt + 1) % 4;
    bus.Tick = (tcnt == 0);
  end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] ex);
    n_cmp++;
    assert (obs === ex) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
    end
  endtask
  always @(negedge clk) begin
    if (bus.RxDone === 1'b1) begin
      exp_t e;
      done_cnt++;
      chk("done_one_clk", {31'd0, prev_done}, 32'd0);
      chk("unexpected_done", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rxdata", {24'd0, bus.RxData}, {24'd0, e.d});
        chk("frame_error", {31'd0, bus.FrameError}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
        chk("parity_error", {31'd0, bus.ParityError}, {31'd0, e.pe});
`endif
      end
    end
    prev_done = bus.RxDone;
  end
  task automatic send(logic [7:0] d, logic stop, logic par);
    exp_t e;
    e.d = d;
    e.fe = ~stop;
    e.pe = ^{d, par};
    q.push_back(e);
    bus.RxD = 1'b0;
    repeat (16) @(negedge clk);
    chk("busy_start", {31'd0, bus.Busy}, 32'd1);
    repeat (48) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RxD = d[i];
      repeat (40) @(negedge clk);
      chk("busy_data", {31'd0, bus.Busy}, 32'd1);
      repeat (24) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    bus.RxD = par;
    repeat (64) @(negedge clk);
`endif
    bus.RxD = stop;
    repeat (48) @(negedge clk);
    chk("busy_after_mid_stop", {31'd0, bus.Busy}, 32'd0);
    repeat (16) @(negedge clk);
  endtask
  initial begin
    logic [7:0] part;
    bus.RxD = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rxdata", {24'd0, bus.RxData}, 32'd0);
    chk("reset_done", {31'd0, bus.RxDone}, 32'd0);
    chk("reset_ferr", {31'd0, bus.FrameError}, 32'd0);
    chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", {31'd0, bus.Busy}, 32'd0);
    send(8'hA5, 1'b1, 1'b0);
    chk("count_a5", done_cnt, 1);
    bus.RxD = 1'b1;
    repeat (64) @(negedge clk);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    chk("count_back_to_back", done_cnt, 3);
    bus.RxD = 1'b0;
    repeat (16) @(negedge clk);
    bus.RxD = 1'b1;
    repeat (48) @(negedge clk);
    chk("glitch_busy", {31'd0, bus.Busy}, 32'd0);
    repeat (64) @(negedge clk);
    chk("glitch_count", done_cnt, 3);
    chk("glitch_rxdata", {24'd0, bus.RxData}, 32'hFF);
    send(8'h3C, 1'b0, 1'b0);
    chk("ferr_held", {31'd0, bus.FrameError}, 32'd1);
    repeat (32) @(negedge clk);
    chk("stuck_low_no_retrigger", {31'd0, bus.Busy}, 32'd0);
    bus.RxD = 1'b1;
    repeat (64) @(negedge clk);
    send(8'h11, 1'b1, 1'b0);
    chk("count_after_ferr", done_cnt, 5);
    chk("ferr_cleared", {31'd0, bus.FrameError}, 32'd0);
    part = 8'h5A;
    bus.RxD = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.RxD = part[i];
      repeat (64) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("midreset_busy", {31'd0, bus.Busy}, 32'd0);
    chk("midreset_rxdata", {24'd0, bus.RxData}, 32'd0);
    chk("midreset_done", {31'd0, bus.RxDone}, 32'd0);
    chk("midreset_ferr", {31'd0, bus.FrameError}, 32'd0);
    repeat (4) @(negedge clk);
    bus.RxD = 1'b1;
    reset = 1'b0;
    repeat (64) @(negedge clk);
    chk("midreset_count", done_cnt, 5);
    send(8'h5A, 1'b1, 1'b0);
    chk("count_after_reset", done_cnt, 6);
`ifdef UART_RX_PARITY_EN
    bus.RxD = 1'b1;
    repeat (64) @(negedge clk);
    send(8'h07, 1'b1, 1'b1);
    send(8'h07, 1'b1, 1'b0);
    chk("count_parity", done_cnt, 8);
    chk("perr_held", {31'd0, bus.ParityError}, 32'd1);
`endif
    repeat (64) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the oversampling Tick from the baud rate generator and deserialises an asynchronous 8N1 line into parallel bytes.
- Sits directly downstream of the baud rate generator. Tick must run at OVERSAMPLE × baud; 16x is the nominal rate.
- Delivers each received byte with a one-clock RxDone strobe and a frame-error flag to the top-level consumer.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first (legal range 5..8).
- OVERSAMPLE, 16, Tick pulses per bit period (power of two, at least 8).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- Tick  input  1  one-clk-wide oversample strobe from the baud rate generator.
- RxD  input  1  asynchronous serial line; idles high.
- RxData  output  DATA_BITS  last received byte; holds until the next frame completes.
- RxDone  output  1  one-clk pulse when a frame completes (valid or errored).
- FrameError  output  1  set with RxDone when the stop bit is sampled low; holds until the next RxDone.
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high) clears state to IDLE:
  - Outputs: RxData=0, RxDone=0, FrameError=0, Busy=0.
  - Internal: tick counter=0, bit counter=0, shift register=0.
  - Synchroniser flops preset to 1.
- RxD passes through a 2-flop synchroniser. All FSM decisions use the synchronised value rxs; a falling edge is detected as prev=1, rxs=0.
- The tick counter is log2(OVERSAMPLE) bits wide and advances only on cycles where Tick=1. The FSM acts only on Tick cycles, except that a falling edge is detected on any cycle.
- IDLE:
  - On a falling edge of rxs: go to START, clear the tick counter, set Busy=1.
- START:
  - When tick count reaches OVERSAMPLE/2-1 (mid start bit), check rxs.
  - rxs=0: clear the tick counter and bit counter, go to DATA.
  - rxs=1: treat as a glitch and return to IDLE. No RxDone, no flag change.
- DATA:
  - Every OVERSAMPLE ticks (tick count = OVERSAMPLE-1, i.e. mid-bit), shift rxs into the MSB of the shift register (right shift, so the LSB arrives first), clear the tick counter, and increment the bit counter.
  - After DATA_BITS samples, go to STOP. With PARITY_EN defined, go to PARITY instead.
- STOP:
  - After OVERSAMPLE ticks, sample rxs.
  - Load RxData from the shift register.
  - Set FrameError = ~rxs.
  - Pulse RxDone for exactly one clk.
  - Go to IDLE with Busy=0.
- Re-arming: IDLE requires a fresh falling edge.
  - A line stuck low after a framing error does not retrigger until it first returns high.
  - A start bit that immediately follows the stop bit is accepted, because the FSM is back in IDLE at mid-stop.
- Latency: RxDone asserts about 9.5 bit times after the start-bit falling edge, plus 2 to 3 clk of synchroniser delay.
- Tick and the falling edge arriving in the same cycle while in IDLE: the edge wins. The counter is cleared, not incremented.
- Reset asserted mid-frame: immediate return to IDLE. The partial byte is discarded and no RxDone is produced.
- A Tick stall (BaudRate change) only freezes the counters. There is no timeout.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP. The parity bit is sampled after OVERSAMPLE ticks.
  - Adds an output port ParityError, 1 bit, even parity. It is set with RxDone when the XOR of the data bits and the parity bit equals 1, and holds until the next RxDone. Reset value is 0.
  - The frame becomes 8E1.
- Undefined: no PARITY state and no ParityError port. The frame is 8N1.

Test Plan:
- 16x Tick (one Tick every 4 clk); send 0xA5 as 8N1 → RxData=0xA5, one RxDone pulse, FrameError=0, Busy high for the whole frame only.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two RxDone pulses, RxData=0x00 then 0xFF, FrameError=0 both times.
- RxD low for 4 Ticks only (glitch) → FSM returns to IDLE, no RxDone, RxData unchanged.
- Send 0x3C with the stop bit driven 0 → RxData=0x3C, RxDone pulse, FrameError=1. FrameError clears on the next good frame (0x11).
- Assert reset after the 4th data bit of 0x5A → Busy=0 and all outputs 0 immediately. No RxDone. A following 0x5A is received correctly.
- UART_RX_PARITY_EN: send 0x07 with parity bit 1 → ParityError=0. Send 0x07 with parity bit 0 → ParityError=1, RxData=0x07.
